// File: rtl/muldiv_sched.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage, producing the HI/LO pair.
// Define MULDIV_FAST_MUL_EN to retire multiplies in a single cycle through a combinational multiplier.
module muldiv_sched #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             stallreq,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             rv_q, rv_d;
  logic             dbz_q, dbz_d;

  // Operand conditioning: magnitudes and sign bits of the incoming operands
  logic             is_div_in, signed_in, sa, sb, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    is_div_in = op_code[1];
    signed_in = ~op_code[0];
    sa        = signed_in & src_a[WIDTH-1];
    sb        = signed_in & src_b[WIDTH-1];
    mag_a     = sa ? (~src_a + WIDTH'(1)) : src_a;
    mag_b     = sb ? (~src_b + WIDTH'(1)) : src_b;
    b_zero    = (src_b == '0);
  end

  // One iteration: restoring shift-subtract for divide, shift-add for multiply.
  // acc_hi holds the partial remainder / upper product, acc_lo the quotient / multiplier.
  logic [WIDTH:0]   div_acc, div_diff, mul_sum;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx, mul_hi_nx, mul_lo_nx;

  always_comb begin
    div_acc   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_acc - {1'b0, opnd_q};
    div_hi_nx = div_diff[WIDTH] ? div_acc[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_lo_nx = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    {mul_hi_nx, mul_lo_nx} = {mul_sum, acc_lo_q[WIDTH-1:1]};
  end

  // Sign restoration applied in FIXUP
  logic [PW-1:0]    prod_mag, prod_fix;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  always_comb begin
    prod_mag = {acc_hi_q, acc_lo_q};
    prod_fix = neg_lo_q ? (~prod_mag + PW'(1)) : prod_mag;
    rem_fix  = neg_hi_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
    quo_fix  = neg_lo_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Extending by sa/sb gives a signed product for MULT and unsigned for MULTU
  logic [PW-1:0] fast_prod;

  always_comb begin
    fast_prod = {{WIDTH{sa}}, src_a} * {{WIDTH{sb}}, src_b};
  end
`endif

  // Next-state, datapath update and stall request
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    rv_d     = rv_q;
    dbz_d    = dbz_q;
    stallreq = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stallreq = op_valid;
        if (op_valid) begin
          cnt_d    = '0;
          is_div_d = is_div_in;
          if (is_div_in && b_zero) begin
            hi_d    = src_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
            rv_d    = 1'b1;
            state_d = S_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div_in) begin
            hi_d    = fast_prod[PW-1:WIDTH];
            lo_d    = fast_prod[WIDTH-1:0];
            dbz_d   = 1'b0;
            rv_d    = 1'b1;
            state_d = S_DONE;
          end
`endif
          else begin
            acc_hi_d = '0;
            neg_lo_d = sa ^ sb;
            if (is_div_in) begin
              acc_lo_d = mag_a;
              opnd_d   = mag_b;
              neg_hi_d = sa;
            end else begin
              acc_lo_d = mag_b;
              opnd_d   = mag_a;
              neg_hi_d = 1'b0;
            end
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        stallreq = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        acc_hi_d = is_div_q ? div_hi_nx : mul_hi_nx;
        acc_lo_d = is_div_q ? div_lo_nx : mul_lo_nx;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        stallreq = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        rv_d    = 1'b1;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!ex_stall) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush abandons the operation but keeps the last architectural result
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      rv_d     = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = dbz_q;
      stallreq = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      rv_q     <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      rv_q     <= rv_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = rv_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: directed vectors, latency/stall checks, flush, reset and ex_stall hold.
module tb_muldiv_sched;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst, op_valid, flush, ex_stall;
  logic [1:0]   op_code;
  logic [W-1:0] src_a, src_b;
  logic         stallreq, busy, result_valid, div_by_zero;
  logic [W-1:0] hi_o, lo_o;

  muldiv_sched #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush), .ex_stall(ex_stall),
    .stallreq(stallreq), .busy(busy), .result_valid(result_valid),
    .hi_o(hi_o), .lo_o(lo_o), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_rv  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every fresh result pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid && !prev_rv) begin
        chk("sb_pending", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_hi", 64'(hi_o), 64'(e.hi));
          chk("sb_lo", 64'(lo_o), 64'(e.lo));
          chk("sb_dbz", 64'(div_by_zero), 64'(e.dbz));
        end
      end
      prev_rv = result_valid;
    end
  end

  // Issue one op; stallreq must be high for cycles 0..lat-1 and result_valid must appear exactly at lat
  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ed, input int lat, input int hold);
    exp_t e;
    int   s_bad = 0;
    int   v_bad = 0;
    int   h_bad = 0;
    @(negedge clk);
    e.hi = eh; e.lo = el; e.dbz = ed;
    sb_q.push_back(e);
    op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
    for (int c = 0; c < lat; c++) begin
      #1;
      if (stallreq !== 1'b1) s_bad++;
      if (c > 0 && result_valid !== 1'b0) v_bad++;
      @(negedge clk);
    end
    ex_stall = (hold > 0);
    #1;
    chk({name, "_stall_inflight"}, 64'(s_bad), 64'd0);
    chk({name, "_early_valid"}, 64'(v_bad), 64'd0);
    chk({name, "_done_stallreq"}, 64'(stallreq), 64'd0);
    chk({name, "_done_valid"}, 64'(result_valid), 64'd1);
    chk({name, "_done_busy"}, 64'(busy), 64'd1);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      ex_stall = (h < hold);
      #1;
      if (result_valid !== 1'b1 || busy !== 1'b1 || stallreq !== 1'b0 ||
          hi_o !== eh || lo_o !== el) h_bad++;
    end
    if (hold > 0) chk({name, "_hold_stable"}, 64'(h_bad), 64'd0);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    chk({name, "_idle_valid"}, 64'(result_valid), 64'd0);
    @(negedge clk);
    #1;
    chk({name, "_no_restart"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0; op_valid = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    op_code = 2'b00; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stallreq", 64'(stallreq), 64'd0);

    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT, 0);

    // Flush at cycle 10 of a DIVU: result 2/14 must survive
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b11; src_a = 32'd50; src_b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stallreq", 64'(stallreq), 64'd0);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_stallreq_after", 64'(stallreq), 64'd0);
    chk("flush_valid", 64'(result_valid), 64'd0);
    chk("flush_hi", 64'(hi_o), 64'd2);
    chk("flush_lo", 64'(lo_o), 64'd14);

    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT, 0);
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, DIV_LAT, 0);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, DIV_LAT, 0);
    run_op("mult_m3_5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MUL_LAT, 0);
    run_op("mult_m3_m5", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15, 1'b0, MUL_LAT, 0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT, 0);
    run_op("divu_by0", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1, 0);
    run_op("div_by0", 2'b10, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, 1, 0);

    // Reset at cycle 5 of a DIVU clears everything
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b11; src_a = 32'd90; src_b = 32'd4;
    repeat (5) @(negedge clk);
    rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_hi", 64'(hi_o), 64'd0);
    chk("midrst_lo", 64'(lo_o), 64'd0);
    chk("midrst_valid", 64'(result_valid), 64'd0);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_stallreq", 64'(stallreq), 64'd0);
    rst = 1'b1;

    run_op("divu_hold", 2'b11, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0, DIV_LAT, 3);
    run_op("multu_small", 2'b01, 32'd12345, 32'd678, 32'h0, 32'd8369910, 1'b0, MUL_LAT, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Multi-cycle multiply/divide sequencer attached to the EX stage; executes MULT/MULTU/DIV/DIVU iteratively and produces the HI/LO result pair.
- Raises a stall request toward the pipeline controller while an operation is in flight, so IF/ID/EX freeze until the result is ready.
- Abortable by pipeline flush.
- Its results feed the HI/LO write path of the later stages.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the clk rising edge.
- op_valid  in  1  EX holds a mul/div instruction; EX keeps it high while stalled.
- op_code  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  rs operand (dividend / multiplicand).
- src_b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  abort the current operation.
- ex_stall  in  1  downstream stall; holds the result in DONE.
- stallreq  out  1  stall request to the pipeline controller.
- busy  out  1  state is not IDLE.
- result_valid  out  1  hi_o/lo_o hold a fresh result.
- hi_o  out  WIDTH  HI: upper product, or remainder.
- lo_o  out  WIDTH  LO: lower product, or quotient.
- div_by_zero  out  1  the result was produced with src_b==0 on a divide.

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE, counter=0.
  - hi_o=0, lo_o=0, result_valid=0, div_by_zero=0.
  - stallreq=0 and busy=0 follow combinationally from IDLE.
  - Reset overrides every other input, including mid-operation.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - stallreq = op_valid & ~flush (combinational, same cycle).
  - On op_valid & ~flush, latch the operands.
  - For signed ops, store operand magnitudes plus sign bits: quotient sign = sa^sb; remainder and product signs follow the same rules as MIPS.
  - Set counter=0, then go to CALC.
- Divide by zero (op_code 1x with src_b==0):
  - Go IDLE->DONE directly.
  - hi_o=src_a, lo_o={WIDTH{1'b1}}, div_by_zero=1.
- CALC:
  - One shift-subtract step (divide) or one shift-add step (multiply) per cycle, counter++.
  - After WIDTH steps (counter==WIDTH-1 at the edge), go to FIXUP.
  - stallreq=1.
- FIXUP:
  - Apply two's-complement negation per the stored signs.
  - Write hi_o/lo_o, set result_valid=1, div_by_zero=0, go to DONE.
  - stallreq=1.
  - 0x80000000 / -1 (DIV) yields lo_o=0x80000000, hi_o=0, with no exception.
- DONE:
  - stallreq=0, so EX advances. result_valid=1.
  - If ex_stall==1, remain in DONE with outputs stable.
  - Otherwise go to IDLE next cycle.
  - op_valid seen in DONE never restarts an operation; the instruction is consumed.
- Latency: the accept edge is cycle 0. FIXUP occurs at cycle WIDTH+1, and result_valid first appears at cycle WIDTH+2 (34 for WIDTH=32).
- Outputs and result_valid:
  - hi_o/lo_o change only in FIXUP, on a divide-by-zero accept, or on reset; otherwise they retain their last value.
  - result_valid clears on the DONE->IDLE transition.
- flush (any state other than reset):
  - Next state is IDLE, counter=0, result_valid=0.
  - hi_o/lo_o are unchanged.
  - stallreq=0 in that same cycle.
  - flush has priority over op_valid and ex_stall.
- Multiply result:
  - Full 2*WIDTH product, with HI as the upper half.
  - MULTU is unsigned; MULT is signed via magnitude plus final negation.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU complete from IDLE to DONE in one edge using a single-cycle signed/unsigned multiplier. result_valid is visible at cycle 1; stallreq is high only in the accept cycle. Division is unchanged.
- Undefined: multiplies use the iterative CALC/FIXUP path, with the same latency as division (WIDTH+2).

Test Plan:
- DIVU src_a=100, src_b=7 -> at cycle 34: lo_o=14, hi_o=2, result_valid=1; stallreq high for cycles 0..33, low at 34.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- MULT -3 * 5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001. Check cycle 34 without MULDIV_FAST_MUL_EN and cycle 1 with it.
- DIVU src_a=0x1234, src_b=0 -> cycle 1: DONE, hi_o=0x1234, lo_o=0xFFFFFFFF, div_by_zero=1.
- Prior result hi/lo=2/14, then DIVU started with flush=1 at cycle 10 -> cycle 11: IDLE, stallreq=0, result_valid=0, hi_o/lo_o remain 2/14. rst=0 at cycle 5 of another op -> all outputs zero next edge.
- ex_stall=1 for 3 cycles on DONE entry -> result_valid held with stable outputs for 3 cycles, then IDLE. op_valid held high throughout -> no second operation starts.
